// File: rtl/hex_text_to_value.sv
// Hex text entry parser: turns a stream of OSD font codes into a right-aligned binary value.
// Define HEX_TEXT_BACKSPACE_EN to make BS_CODE delete the most recent digit.
module hex_text_to_value #(
  parameter int          DIGITS    = 8,
  parameter logic [7:0]  TERM_CODE = 8'd1,
  parameter logic [7:0]  BS_CODE   = 8'd2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic [7:0]                   char_in,
  input  logic                         char_valid,
  output logic                         char_ready,
  output logic [4*DIGITS-1:0]          value,
  output logic                         value_valid,
  output logic                         err,
  output logic [1:0]                   err_code,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count
);
  localparam int W  = 4*DIGITS;
  localparam int CW = $clog2(DIGITS+1);

  typedef enum logic [1:0] {S_ACCUM, S_DONE, S_ERR} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_PUSH, OP_COMMIT, OP_POP, OP_FAIL} op_t;

  state_t       state;
  logic [W-1:0] acc;
  logic         is_hex;
  logic [3:0]   nib;
  op_t          op;
  logic [1:0]   fail_code;
  logic         accept;

  assign accept = char_valid && char_ready;

  always_comb begin
    is_hex = 1'b0;
    nib    = 4'd0;
    if (char_in >= 8'd16 && char_in <= 8'd25) begin
      is_hex = 1'b1;
      nib    = 4'(char_in - 8'd16);
    end else if (char_in >= 8'd33 && char_in <= 8'd38) begin
      is_hex = 1'b1;
      nib    = 4'(char_in - 8'd23);
    end
  end

  // Decide what an accepted character does; the register block just applies it.
  always_comb begin
    op        = OP_NONE;
    fail_code = 2'd0;
    if (state == S_ACCUM && accept) begin
      if (is_hex) begin
        if (digit_count < CW'(DIGITS)) op = OP_PUSH;
        else begin op = OP_FAIL; fail_code = 2'd2; end
      end else if (char_in == TERM_CODE) begin
        if (digit_count != '0) op = OP_COMMIT;
        else begin op = OP_FAIL; fail_code = 2'd3; end
      end else if (char_in == BS_CODE) begin
`ifdef HEX_TEXT_BACKSPACE_EN
        op = OP_POP;
`else
        op = OP_FAIL; fail_code = 2'd1;
`endif
      end else begin
        op = OP_FAIL; fail_code = 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_ACCUM;
      acc         <= '0;
      digit_count <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'd0;
      char_ready  <= 1'b1;
    end else begin
      value_valid <= 1'b0;
      err         <= 1'b0;
      if (clear) begin
        state       <= S_ACCUM;
        acc         <= '0;
        digit_count <= '0;
        char_ready  <= 1'b1;
      end else begin
        case (state)
          S_ACCUM: begin
            case (op)
              OP_PUSH: begin
                acc         <= {acc[W-5:0], nib};
                digit_count <= digit_count + CW'(1);
              end
`ifdef HEX_TEXT_BACKSPACE_EN
              OP_POP: begin
                // Backspace on an empty entry is silently consumed.
                if (digit_count != '0) begin
                  acc         <= acc >> 4;
                  digit_count <= digit_count - CW'(1);
                end
              end
`endif
              OP_COMMIT: begin
                value       <= acc;
                value_valid <= 1'b1;
                state       <= S_DONE;
                char_ready  <= 1'b0;
                acc         <= '0;
                digit_count <= '0;
              end
              OP_FAIL: begin
                err_code    <= fail_code;
                err         <= 1'b1;
                state       <= S_ERR;
                char_ready  <= 1'b0;
                acc         <= '0;
                digit_count <= '0;
              end
              default: ;
            endcase
          end
          S_DONE, S_ERR: begin
            state       <= S_ACCUM;
            char_ready  <= 1'b1;
            acc         <= '0;
            digit_count <= '0;
          end
          default: begin
            state      <= S_ACCUM;
            char_ready <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule
